// File: rtl/pe_lut_pkg.sv
// Shared constants, types and helpers for the PE-LUT job sequencer.
// Holds the register map, the control-word layout, the FSM state type and the bus command struct.
package pe_lut_pkg;

    localparam int NUM_CSR = 16;
    localparam int CSR_W   = 35;
    localparam int IDX_W   = $clog2(NUM_CSR);

    localparam logic [63:0] CSR_MEM_BASE_ADDR = 64'h0000_0000_6000_0000;
    localparam logic [63:0] CSR_CONTROL_ADDR  = 64'h0000_0000_600F_0000;

    localparam int EN_LSB    = 0;
    localparam int CFG_LSB   = 16;
    localparam int READY_LSB = 48;

    localparam logic [7:0] SLOT_BYTE_EN = 8'h1F;
    localparam logic [7:0] CTRL_BYTE_EN = 8'h07;
    localparam logic [7:0] READ_BYTE_EN = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ENABLE,
        ST_POLL_REQ,
        ST_POLL_WAIT,
        ST_POLL_GAP,
        ST_CLEAR,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic        req;
        logic        write_en;
        logic [7:0]  byte_en;
        logic [63:0] addr;
        logic [63:0] wdata;
    } mem_cmd_t;

    function automatic logic [63:0] csr_slot_addr(input logic [IDX_W-1:0] idx);
        return CSR_MEM_BASE_ADDR + {{(64-IDX_W-3){1'b0}}, idx, 3'b000};
    endfunction

    function automatic logic [63:0] ctrl_word(input logic [NUM_CSR-1:0] mask,
                                              input logic [1:0]         cfg);
        logic [63:0] w;
        w                    = '0;
        w[EN_LSB +: NUM_CSR] = mask;
        w[CFG_LSB +: 2]      = cfg;
        return w;
    endfunction

endpackage

// File: rtl/pe_lut_poll_timer.sv
// Down-counter shared by the read-latency wait and the inter-poll gap.
// 'last' is high in the final cycle of a loaded interval (count of 1, or 0 when idle).
module pe_lut_poll_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         tick,
    output logic         last
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (tick && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign last = (count <= W'(1));

endmodule

// File: rtl/pe_lut_job_sequencer.sv
// Runs one PE-LUT job over the mem_* register port: load slots, enable, poll ready, clear, report.
// One bus request outstanding at most; a new descriptor is taken only in IDLE.
module pe_lut_job_sequencer
    import pe_lut_pkg::*;
#(
    parameter int READ_LATENCY = 2,
    parameter int POLL_GAP     = 8,
    parameter int MAX_POLLS    = 1024
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     job_valid_i,
    output logic                     job_ready_o,
    input  logic [NUM_CSR-1:0]       job_mask_i,
    input  logic [NUM_CSR*CSR_W-1:0] job_csr_data_i,
    input  logic [1:0]               job_result_cfg_i,
    output logic                     mem_req_o,
    output logic                     mem_write_en_o,
    output logic [7:0]               mem_byte_en_o,
    output logic [63:0]              mem_addr_o,
    output logic [63:0]              mem_wdata_o,
    input  logic [63:0]              mem_rdata_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     error_o,
    output logic [15:0]              poll_count_o
);

    localparam int               TIMER_W     = 16;
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_CSR - 1);
    localparam logic [31:0]      MAX_POLLS_W = 32'(MAX_POLLS);

    state_t               state_q, state_d;
    logic [NUM_CSR-1:0]   mask_q;
    logic [1:0]           cfg_q;
    logic [CSR_W-1:0]     data_q [NUM_CSR];
    logic [IDX_W-1:0]     idx_q;
    logic [15:0]          poll_count_q;
    logic                 timeout_q;

    mem_cmd_t             cmd;
    logic                 timer_load;
    logic [TIMER_W-1:0]   timer_val;
    logic                 timer_tick;
    logic                 timer_last;

    logic                 accept;
    logic                 ready_ok;
    logic                 poll_limit;
    logic                 timeout_hit;
    logic                 unused_rdata;

    assign accept      = (state_q == ST_IDLE) && job_valid_i;
    // Ready bits of disabled slots are masked out so they cannot hold up completion.
    assign ready_ok    = ((mem_rdata_i[READY_LSB +: NUM_CSR] & mask_q) == mask_q);
    assign poll_limit  = ({16'b0, poll_count_q} == MAX_POLLS_W);
    assign timeout_hit = (state_q == ST_POLL_WAIT) && timer_last && !ready_ok && poll_limit;
    assign unused_rdata = ^mem_rdata_i[READY_LSB-1:0];

    pe_lut_poll_timer #(
        .W (TIMER_W)
    ) u_timer (
        .clk      (clk_i),
        .rst      (rst_i),
        .load     (timer_load),
        .load_val (timer_val),
        .tick     (timer_tick),
        .last     (timer_last)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            mask_q       <= '0;
            cfg_q        <= '0;
            idx_q        <= '0;
            poll_count_q <= '0;
            timeout_q    <= 1'b0;
            for (int i = 0; i < NUM_CSR; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            if (accept) begin
                mask_q       <= job_mask_i;
                cfg_q        <= job_result_cfg_i;
                idx_q        <= '0;
                poll_count_q <= '0;
                timeout_q    <= 1'b0;
                for (int i = 0; i < NUM_CSR; i++) begin
                    data_q[i] <= job_csr_data_i[i*CSR_W +: CSR_W];
                end
            end
            if (state_q == ST_LOAD) begin
                idx_q <= idx_q + IDX_W'(1);
            end
            if ((state_q == ST_POLL_REQ) && (poll_count_q != 16'hFFFF)) begin
                poll_count_q <= poll_count_q + 16'd1;
            end
            if (timeout_hit) begin
                timeout_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cmd        = '0;
        timer_load = 1'b0;
        timer_val  = '0;
        timer_tick = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (job_valid_i) begin
                    state_d = (job_mask_i == '0) ? ST_DONE : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (mask_q[idx_q]) begin
                    cmd.req                = 1'b1;
                    cmd.write_en           = 1'b1;
                    cmd.byte_en            = SLOT_BYTE_EN;
                    cmd.addr               = csr_slot_addr(idx_q);
                    cmd.wdata[CSR_W-1:0]   = data_q[idx_q];
                end
                if (idx_q == LAST_IDX) begin
                    state_d = ST_ENABLE;
                end
            end
            ST_ENABLE: begin
                cmd.req      = 1'b1;
                cmd.write_en = 1'b1;
                cmd.byte_en  = CTRL_BYTE_EN;
                cmd.addr     = CSR_CONTROL_ADDR;
                cmd.wdata    = ctrl_word(mask_q, cfg_q);
                state_d      = ST_POLL_REQ;
            end
            ST_POLL_REQ: begin
                cmd.req    = 1'b1;
                cmd.byte_en = READ_BYTE_EN;
                cmd.addr   = CSR_CONTROL_ADDR;
                timer_load = 1'b1;
                timer_val  = TIMER_W'(READ_LATENCY);
                state_d    = ST_POLL_WAIT;
            end
            ST_POLL_WAIT: begin
                timer_tick = 1'b1;
                if (timer_last) begin
                    if (ready_ok || poll_limit) begin
                        state_d = ST_CLEAR;
                    end else if (POLL_GAP == 0) begin
                        state_d = ST_POLL_REQ;
                    end else begin
                        timer_load = 1'b1;
                        timer_val  = TIMER_W'(POLL_GAP);
                        state_d    = ST_POLL_GAP;
                    end
                end
            end
            ST_POLL_GAP: begin
                timer_tick = 1'b1;
                if (timer_last) begin
                    state_d = ST_POLL_REQ;
                end
            end
            ST_CLEAR: begin
                cmd.req      = 1'b1;
                cmd.write_en = 1'b1;
                cmd.byte_en  = CTRL_BYTE_EN;
                cmd.addr     = CSR_CONTROL_ADDR;
                state_d      = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign mem_req_o      = cmd.req;
    assign mem_write_en_o = cmd.write_en;
    assign mem_byte_en_o  = cmd.byte_en;
    assign mem_addr_o     = cmd.addr;
    assign mem_wdata_o    = cmd.wdata;

    assign job_ready_o  = (state_q == ST_IDLE);
    assign busy_o       = (state_q != ST_IDLE);
    assign done_o       = (state_q == ST_DONE);
    assign error_o      = (state_q == ST_DONE) && timeout_q;
    assign poll_count_o = poll_count_q;

endmodule

// File: tb/tb_pe_lut_job_sequencer.sv
// Directed bench for pe_lut_job_sequencer with a latency-accurate control-register read model.
module tb_pe_lut_job_sequencer;

    localparam int NCSR = 16;
    localparam int CW   = 35;
    localparam logic [63:0] CTRL = 64'h0000_0000_600F_0000;
    localparam logic [63:0] BASE = 64'h0000_0000_6000_0000;

    logic               clk_i = 1'b0;
    logic               rst_i;
    logic               job_valid_i;
    logic               job_ready_o;
    logic [NCSR-1:0]    job_mask_i;
    logic [NCSR*CW-1:0] job_csr_data_i;
    logic [1:0]         job_result_cfg_i;
    logic               mem_req_o;
    logic               mem_write_en_o;
    logic [7:0]         mem_byte_en_o;
    logic [63:0]        mem_addr_o;
    logic [63:0]        mem_wdata_o;
    logic [63:0]        mem_rdata_i;
    logic               busy_o;
    logic               done_o;
    logic               error_o;
    logic [15:0]        poll_count_o;

    pe_lut_job_sequencer #(
        .READ_LATENCY (2),
        .POLL_GAP     (8),
        .MAX_POLLS    (4)
    ) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .job_valid_i      (job_valid_i),
        .job_ready_o      (job_ready_o),
        .job_mask_i       (job_mask_i),
        .job_csr_data_i   (job_csr_data_i),
        .job_result_cfg_i (job_result_cfg_i),
        .mem_req_o        (mem_req_o),
        .mem_write_en_o   (mem_write_en_o),
        .mem_byte_en_o    (mem_byte_en_o),
        .mem_addr_o       (mem_addr_o),
        .mem_wdata_o      (mem_wdata_o),
        .mem_rdata_i      (mem_rdata_i),
        .busy_o           (busy_o),
        .done_o           (done_o),
        .error_o          (error_o),
        .poll_count_o     (poll_count_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    // Read model: data is valid only exactly two cycles after the request; otherwise
    // it shows all ready bits set, so sampling at the wrong cycle finishes too early.
    int          reads_seen = 0;
    int          read_base  = 0;
    int          ready_after = 1;
    logic [15:0] ready_pat   = 16'hFFFF;
    logic [15:0] partial_pat = 16'h0000;
    logic        p1 = 1'b0, p2 = 1'b0;
    logic [15:0] resp1 = '0, resp2 = '0;

    always @(posedge clk_i) begin
        p1    <= mem_req_o && !mem_write_en_o;
        p2    <= p1;
        resp2 <= resp1;
        if (mem_req_o && !mem_write_en_o) begin
            reads_seen <= reads_seen + 1;
            resp1 <= (reads_seen + 1 - read_base >= ready_after) ? ready_pat : partial_pat;
        end
    end
    assign mem_rdata_i = p2 ? {resp2, 48'h0123_4567_89AB} : 64'hFFFF_0000_0000_0000;

    typedef struct {
        int          cyc;
        logic        we;
        logic [7:0]  be;
        logic [63:0] addr;
        logic [63:0] wdata;
    } op_t;

    op_t ops[$];
    int  acc_q[$];
    int  done_q[$];
    int  err_with_done = 0;
    int  err_alone     = 0;

    always @(negedge clk_i) begin
        op_t o;
        if (mem_req_o) begin
            o.cyc = cyc; o.we = mem_write_en_o; o.be = mem_byte_en_o;
            o.addr = mem_addr_o; o.wdata = mem_wdata_o;
            ops.push_back(o);
        end
        if (job_valid_i && job_ready_o) acc_q.push_back(cyc);
        if (done_o) begin
            done_q.push_back(cyc);
            if (error_o) err_with_done++;
        end else if (error_o) begin
            err_alone++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_wr(input string tag, input int idx, input logic [63:0] addr,
                          input logic [63:0] wdata, input logic [7:0] be, input int cyc_exp);
        if (idx >= ops.size()) begin
            chk({tag, "_present"}, 64'(ops.size()), 64'(idx + 1));
            return;
        end
        chk({tag, "_we"},    64'(ops[idx].we), 64'd1);
        chk({tag, "_addr"},  ops[idx].addr, addr);
        chk({tag, "_wdata"}, ops[idx].wdata, wdata);
        chk({tag, "_be"},    64'(ops[idx].be), 64'(be));
        chk({tag, "_cyc"},   64'(ops[idx].cyc), 64'(cyc_exp));
    endtask

    task automatic chk_rd(input string tag, input int idx, input int cyc_exp);
        if (idx >= ops.size()) begin
            chk({tag, "_present"}, 64'(ops.size()), 64'(idx + 1));
            return;
        end
        chk({tag, "_we"},   64'(ops[idx].we), 64'd0);
        chk({tag, "_addr"}, ops[idx].addr, CTRL);
        chk({tag, "_cyc"},  64'(ops[idx].cyc), 64'(cyc_exp));
    endtask

    task automatic tick_in();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_logs();
        ops.delete(); acc_q.delete(); done_q.delete();
        err_with_done = 0; err_alone = 0;
        read_base = reads_seen;
    endtask

    task automatic set_job(input logic [15:0] m, input logic [1:0] c, input logic [CW-1:0] tag);
        job_mask_i       = m;
        job_result_cfg_i = c;
        for (int i = 0; i < NCSR; i++) job_csr_data_i[i*CW +: CW] = tag | CW'(i);
    endtask

    task automatic wait_done(input int budget, input string tag);
        int n = 0;
        while (done_q.size() == 0 && n < budget) begin
            @(negedge clk_i); #1; n++;
        end
        if (done_q.size() == 0) chk({tag, "_done_seen"}, 64'd0, 64'd1);
        tick_in();
    endtask

    function automatic int acc_at(input int i);
        return (acc_q.size() > i) ? acc_q[i] : -10000;
    endfunction

    function automatic int done_at(input int i);
        return (done_q.size() > i) ? done_q[i] : -20000;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int a;
        int n;
        rst_i = 1'b1; job_valid_i = 1'b0;
        job_mask_i = '0; job_csr_data_i = '0; job_result_cfg_i = '0;
        repeat (3) tick_in();
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("rst_ready", 64'(job_ready_o), 64'd1);
        chk("rst_busy",  64'(busy_o),      64'd0);
        chk("rst_done",  64'(done_o),      64'd0);
        chk("rst_error", 64'(error_o),     64'd0);
        chk("rst_req",   64'(mem_req_o),   64'd0);
        chk("rst_poll",  64'(poll_count_o), 64'd0);
        chk("rst_addr",  mem_addr_o,       64'd0);

        // Full load: ready on the 3rd read.
        tick_in(); clear_logs();
        ready_after = 3; ready_pat = 16'hFFFF; partial_pat = 16'h7FFF;
        set_job(16'hFFFF, 2'd1, 35'h4_0000_0000); job_valid_i = 1'b1;
        tick_in(); job_valid_i = 1'b0;
        wait_done(200, "full");
        a = acc_at(0);
        chk("full_latency", 64'(done_at(0) - a), 64'd44);
        chk("full_nops", 64'(ops.size()), 64'd21);
        for (int i = 0; i < NCSR; i++)
            chk_wr($sformatf("full_slot%0d", i), i, BASE + 64'(8 * i),
                   64'h4_0000_0000 | 64'(i), 8'h1F, a + 1 + i);
        chk_wr("full_enable", 16, CTRL, 64'h0000_0000_0001_FFFF, 8'h07, a + 17);
        chk_rd("full_rd1", 17, a + 18);
        chk_rd("full_rd2", 18, a + 29);
        chk_rd("full_rd3", 19, a + 40);
        chk_wr("full_clear", 20, CTRL, 64'd0, 8'h07, a + 43);
        chk("full_poll", 64'(poll_count_o), 64'd3);
        chk("full_err",  64'(err_with_done + err_alone), 64'd0);

        // Sparse mask: disabled-slot ready bits are ignored.
        clear_logs();
        ready_after = 2; ready_pat = 16'h0005; partial_pat = 16'hFFFA;
        set_job(16'h0005, 2'd0, 35'h5_A5A5_A500); job_valid_i = 1'b1;
        tick_in(); job_valid_i = 1'b0;
        wait_done(200, "sparse");
        a = acc_at(0);
        chk("sparse_latency", 64'(done_at(0) - a), 64'd33);
        chk("sparse_nops", 64'(ops.size()), 64'd6);
        chk_wr("sparse_slot0", 0, BASE, 64'h5_A5A5_A500, 8'h1F, a + 1);
        chk_wr("sparse_slot2", 1, BASE + 64'h10, 64'h5_A5A5_A502, 8'h1F, a + 3);
        chk_wr("sparse_enable", 2, CTRL, 64'h0000_0000_0000_0005, 8'h07, a + 17);
        chk_rd("sparse_rd2", 4, a + 29);
        chk("sparse_poll", 64'(poll_count_o), 64'd2);

        // Timeout after MAX_POLLS reads.
        clear_logs();
        ready_after = 1000; partial_pat = 16'h7FFE;
        set_job(16'h8001, 2'd2, 35'h0_0000_1000); job_valid_i = 1'b1;
        tick_in(); job_valid_i = 1'b0;
        wait_done(200, "tmo");
        a = acc_at(0);
        chk("tmo_latency", 64'(done_at(0) - a), 64'd55);
        chk("tmo_nops", 64'(ops.size()), 64'd8);
        chk_wr("tmo_slot15", 1, BASE + 64'h78, 64'h100F, 8'h1F, a + 16);
        chk_wr("tmo_enable", 2, CTRL, 64'h0000_0000_0002_8001, 8'h07, a + 17);
        chk_rd("tmo_rd1", 3, a + 18);
        chk_rd("tmo_rd2", 4, a + 29);
        chk_rd("tmo_rd3", 5, a + 40);
        chk_rd("tmo_rd4", 6, a + 51);
        chk_wr("tmo_clear", 7, CTRL, 64'd0, 8'h07, a + 54);
        chk("tmo_err_with_done", 64'(err_with_done), 64'd1);
        chk("tmo_err_alone", 64'(err_alone), 64'd0);
        chk("tmo_poll", 64'(poll_count_o), 64'd4);
        repeat (3) tick_in();
        chk("tmo_poll_hold", 64'(poll_count_o), 64'd4);

        // Empty mask.
        clear_logs();
        set_job(16'h0000, 2'd0, 35'h0); job_valid_i = 1'b1;
        tick_in(); job_valid_i = 1'b0;
        wait_done(10, "zero");
        chk("zero_latency", 64'(done_at(0) - acc_at(0)), 64'd1);
        chk("zero_nops", 64'(ops.size()), 64'd0);
        chk("zero_err", 64'(err_with_done + err_alone), 64'd0);
        chk("zero_poll", 64'(poll_count_o), 64'd0);

        // Reset in the middle of LOAD at index 5.
        clear_logs();
        ready_after = 1; ready_pat = 16'hFFFF; partial_pat = 16'h0000;
        set_job(16'hFFFF, 2'd3, 35'h7_0000_0000); job_valid_i = 1'b1;
        tick_in(); job_valid_i = 1'b0;
        repeat (5) tick_in();
        rst_i = 1'b1;
        @(negedge clk_i);
        chk("rstmid_req_before", 64'(mem_req_o), 64'd1);
        chk("rstmid_addr_before", mem_addr_o, BASE + 64'h28);
        tick_in(); rst_i = 1'b0;
        @(negedge clk_i);
        chk("rstmid_req",   64'(mem_req_o),   64'd0);
        chk("rstmid_ready", 64'(job_ready_o), 64'd1);
        chk("rstmid_busy",  64'(busy_o),      64'd0);
        repeat (40) @(negedge clk_i);
        #1;
        chk("rstmid_nops", 64'(ops.size()), 64'd6);
        chk("rstmid_no_done", 64'(done_q.size()), 64'd0);
        tick_in(); clear_logs();
        set_job(16'hFFFF, 2'd3, 35'h7_0000_0000); job_valid_i = 1'b1;
        tick_in(); job_valid_i = 1'b0;
        wait_done(100, "after_rst");
        a = acc_at(0);
        chk("after_rst_latency", 64'(done_at(0) - a), 64'd22);
        chk("after_rst_nops", 64'(ops.size()), 64'd19);
        chk_wr("after_rst_slot5", 5, BASE + 64'h28, 64'h7_0000_0005, 8'h1F, a + 6);
        chk_wr("after_rst_enable", 16, CTRL, 64'h0000_0000_0003_FFFF, 8'h07, a + 17);
        chk_rd("after_rst_rd1", 17, a + 18);
        chk_wr("after_rst_clear", 18, CTRL, 64'd0, 8'h07, a + 21);
        chk("after_rst_poll", 64'(poll_count_o), 64'd1);

        // Back-to-back jobs with valid held high.
        clear_logs();
        set_job(16'h0003, 2'd1, 35'h1_0000_0000); job_valid_i = 1'b1;
        tick_in();
        set_job(16'h0010, 2'd2, 35'h2_0000_0000);
        n = 0;
        while (acc_q.size() < 2 && n < 200) begin
            @(negedge clk_i); #1; n++;
        end
        tick_in(); job_valid_i = 1'b0;
        n = 0;
        while (done_q.size() < 2 && n < 200) begin
            @(negedge clk_i); #1; n++;
        end
        tick_in();
        chk("b2b_accepts", 64'(acc_q.size()), 64'd2);
        chk("b2b_accept_gap", 64'(acc_at(1) - done_at(0)), 64'd1);
        chk("b2b_latency2", 64'(done_at(1) - acc_at(1)), 64'd22);
        chk("b2b_nops", 64'(ops.size()), 64'd9);
        chk_wr("b2b_a_slot0", 0, BASE, 64'h1_0000_0000, 8'h1F, acc_at(0) + 1);
        chk_wr("b2b_b_slot4", 5, BASE + 64'h20, 64'h2_0000_0004, 8'h1F, acc_at(1) + 5);
        chk_wr("b2b_b_enable", 6, CTRL, 64'h0000_0000_0002_0010, 8'h07, acc_at(1) + 17);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pe_lut_job_sequencer.md
# pe_lut_job_sequencer

Bus-master controller that runs one PE-LUT accelerator job end to end over the accelerator's memory-mapped register port. For each job it writes the selected CSR slots, enables them with the result configuration, and polls the control register until every enabled slot reports ready or a timeout occurs. It then disables the slots and reports completion. It sits between a job source (DMA or host command queue) and the PE-LUT wrapper's mem_* slave port, so software no longer has to spin on the control register.

## Interface
- NUM_CSR, 16, number of CSR slots
- CSR_W, 35, CSR slot data width
- READ_LATENCY, 2, cycles from a read request cycle to valid mem_rdata_i
- POLL_GAP, 8, idle cycles between consecutive status reads
- MAX_POLLS, 1024, status reads before timeout (≥1)
- clk_i  in  1  clock
- rst_i  in  1  reset; synchronous, active-high
- job_valid_i  in  1  descriptor valid
- job_ready_o  out  1  descriptor accepted when high together with job_valid_i
- job_mask_i  in  NUM_CSR  slots to load, enable and wait on
- job_csr_data_i  in  NUM_CSR×CSR_W  slot payloads; slot i occupies bits [i*CSR_W +: CSR_W]
- job_result_cfg_i  in  2  result configuration; goes to control bits [17:16]
- mem_req_o  out  1  single-cycle bus request
- mem_write_en_o  out  1  1 = write, 0 = read
- mem_byte_en_o  out  8  byte enables
- mem_addr_o  out  64  byte address
- mem_wdata_o  out  64  write data
- mem_rdata_i  in  64  read data, valid READ_LATENCY cycles after the read request cycle
- busy_o  out  1  high in every state except IDLE
- done_o  out  1  one-cycle pulse when a job finishes, whether successful or timed out
- error_o  out  1  one-cycle pulse, coincident with done_o, on timeout
- poll_count_o  out  16  status reads issued for the current or last job

## Operation
- Address map: CSR slot i is at 0x6000_0000 + 8*i. The control register is at 0x600f_0000. In the control register, bits [15:0] are the enables, [17:16] the result config, [63:48] the ready bits.
- States: IDLE, LOAD, ENABLE, POLL_REQ, POLL_WAIT, POLL_GAP, CLEAR, DONE.
- IDLE:
  - job_ready_o = 1.
  - On handshake, latch mask, data and result_cfg, clear poll_count, clear slot index.
  - If mask == 0, go to DONE. Otherwise go to LOAD.
- LOAD walks index 0..NUM_CSR-1 at one index per cycle.
  - If mask[idx] is set: issue a write with addr = slot address, wdata = zero-extended data[idx], byte_en = 8'h1F.
  - If mask[idx] is clear: no request that cycle.
  - After the last index, go to ENABLE.
- ENABLE: write control with wdata = {46'b0, result_cfg, mask} and byte_en = 8'h07. Go to POLL_REQ.
- POLL_REQ:
  - Issue a read of control and increment poll_count.
  - Go to POLL_WAIT and load a wait counter with READ_LATENCY.
- POLL_WAIT: decrement the counter. When it reaches 0, sample mem_rdata_i.
  - If (rdata[63:48] & mask) == mask, go to CLEAR.
  - Else if poll_count == MAX_POLLS, set the timeout flag and go to CLEAR.
  - Else go to POLL_GAP.
- POLL_GAP: wait POLL_GAP cycles, then go to POLL_REQ.
- CLEAR: write control with wdata = 0 and byte_en = 8'h07. Go to DONE.
- DONE: pulse done_o, and pulse error_o if the timeout flag is set. Go to IDLE.
- poll_count_o saturates at 16'hFFFF and holds its value until the next job is accepted.
- Only one request is outstanding at any time. The block never issues back-to-back requests while a read is pending.

## Timing
- Reset values: every output is 0 except job_ready_o, which is 1. State is IDLE, all latched descriptor fields and counters are 0.
- job_ready_o is decoded from state only and does not depend on job_valid_i.
- Accept in cycle T; the first LOAD cycle is T+1. LOAD lasts exactly NUM_CSR cycles. ENABLE is 1 cycle.
- Read issued in cycle R: mem_rdata_i is sampled in cycle R+READ_LATENCY.
- Best case from accept to done_o with a nonzero mask: NUM_CSR + 1 + 1 + READ_LATENCY + 1 + 1 cycles (T+1 to done).
- mask == 0: done_o in cycle T+1 with no bus activity and no error_o.
- The next job can be accepted in the cycle after DONE.
- Reset asserted in any state returns to IDLE on the next edge. No further requests are issued, and no done_o or error_o is produced for the aborted job.
- mem_* outputs other than mem_req_o are don't-care when mem_req_o = 0 but are driven to 0.

## Structure
- pe_lut_pkg holds:
  - address constants CSR_MEM_BASE_ADDR, CSR_CONTROL_ADDR
  - control bit-field positions (EN_LSB=0, CFG_LSB=16, READY_LSB=48)
  - CSR_W and NUM_CSR
  - the state enum type
- One sub-module, pe_lut_poll_timer, holds the shared down-counter used for both the READ_LATENCY wait and the POLL_GAP wait. The FSM, LOAD index and poll counter stay in the top module.

## Test plan
- Full load: mask 16'hFFFF, slot i data = 35'h4_0000_0000 | i. Expect:
  - 16 writes to 0x6000_0000..0x6000_0078 with byte_en 8'h1F
  - a control write of 64'h0000_0000_0001_FFFF when result_cfg = 1
  - the model returns ready 16'hFFFF on the 3rd read
  - poll_count_o = 3, then a control write of 0, then done_o with error_o = 0
- Sparse mask 16'h0005: writes only to 0x6000_0000 and 0x6000_0010. LOAD still lasts 16 cycles. The wait ignores ready bits for disabled slots, e.g. rdata[63:48] = 16'h0005 completes.
- Timeout with MAX_POLLS=4 and ready never set: exactly 4 reads, each separated by READ_LATENCY+1+POLL_GAP cycles. Then a control write of 0, and done_o and error_o in the same cycle. poll_count_o = 4.
- mask 0: done_o in the cycle after accept, mem_req_o never asserted, error_o = 0.
- Reset mid-LOAD at index 5: mem_req_o is 0 from the next edge, job_ready_o = 1, and no done_o. A following full job runs normally.
- Back-to-back jobs with job_valid_i held high: the second accept happens in the cycle after the first done_o. The second job's latched mask, data and result_cfg are used, not the first's.
